// File: rtl/disp_page_sched_if.sv
// Signal bundle between the display page scheduler and its surroundings:
// debug sources and buttons in, scan-driver controls out.
interface disp_page_sched_if;
  logic        btn_next;
  logic        btn_auto;
  logic [15:0] src0_data;
  logic [15:0] src1_data;
  logic [15:0] src2_data;
  logic [15:0] src3_data;
  logic [3:0]  src_valid;
  logic        scan_tick;
  logic [15:0] disp_data;
  logic        clr;
  logic [1:0]  page;
  logic        auto_mode;

  modport master (
    output btn_next, btn_auto, src0_data, src1_data, src2_data, src3_data, src_valid,
    input  scan_tick, disp_data, clr, page, auto_mode
  );

  modport slave (
    input  btn_next, btn_auto, src0_data, src1_data, src2_data, src3_data, src_valid,
    output scan_tick, disp_data, clr, page, auto_mode
  );
endinterface

// File: rtl/disp_page_sched.sv
// Shares one 4-digit display between four debug sources: scan tick, button debounce,
// auto-rotation and page blanking. Define DISP_PAGE_TAG_EN to show the page number in the top digit.
module disp_page_sched #(
  parameter int unsigned SCAN_DIV    = 526316,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned AUTO_TICKS  = 380,
  parameter int unsigned BLANK_TICKS = 19
) (
  input  logic              CLK,
  input  logic              RST_n,
  disp_page_sched_if.slave  bus
);
  localparam int unsigned SW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
  localparam int unsigned AW  = $clog2(AUTO_TICKS + 1);
  localparam int unsigned BW  = $clog2(BLANK_TICKS + 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state_q, state_d;
  logic [1:0]          page_q, page_d;
  logic [BW-1:0]       blk_cnt_q, blk_cnt_d;
  logic [15:0]         disp_q, disp_d;
  logic [SW-1:0]       scan_cnt_q;
  logic                scan_tick;
  logic [1:0]          raw, sync1_q, sync2_q, db_q, db_d, db_prev_q;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic                next_p, auto_p;
  logic                auto_mode_q;
  logic [AW-1:0]       auto_cnt_q, auto_cnt_d;
  logic                auto_adv;
  logic                cand_found;
  logic [1:0]          cand_page;
  logic [15:0]         src_sel, shown;
  logic                clr_o;

  // Scan divider
  assign scan_tick = (scan_cnt_q == SW'(SCAN_DIV - 1));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)         scan_cnt_q <= '0;
    else if (scan_tick) scan_cnt_q <= '0;
    else                scan_cnt_q <= scan_cnt_q + SW'(1);
  end

  // Buttons: bit 0 = next, bit 1 = auto
  assign raw = {bus.btn_auto, bus.btn_next};

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) db_d[i] = sync2_q[i];
        else                                   db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign next_p = db_q[0] & ~db_prev_q[0];
  assign auto_p = db_q[1] & ~db_prev_q[1];

  // Auto-rotation counts scan ticks only while showing a page
  assign auto_adv = auto_mode_q && (state_q == SHOW) && scan_tick &&
                    (auto_cnt_q == AW'(AUTO_TICKS - 1));

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    if (auto_p || !auto_mode_q || (state_q != SHOW)) auto_cnt_d = '0;
    else if (auto_adv)                               auto_cnt_d = '0;
    else if (scan_tick)                              auto_cnt_d = auto_cnt_q + AW'(1);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      auto_mode_q <= 1'b0;
      auto_cnt_q  <= '0;
    end else begin
      auto_mode_q <= auto_mode_q ^ auto_p;
      auto_cnt_q  <= auto_cnt_d;
    end
  end

  // First valid source after the current page, wrapping
  always_comb begin
    logic [1:0] idx;
    cand_found = 1'b0;
    cand_page  = page_q;
    for (int unsigned k = 1; k < 4; k++) begin
      idx = page_q + 2'(k);
      if (!cand_found && bus.src_valid[idx]) begin
        cand_found = 1'b1;
        cand_page  = idx;
      end
    end
  end

  always_comb begin
    case (page_q)
      2'd0:    src_sel = bus.src0_data;
      2'd1:    src_sel = bus.src1_data;
      2'd2:    src_sel = bus.src2_data;
      default: src_sel = bus.src3_data;
    endcase
    shown = src_sel;
`ifdef DISP_PAGE_TAG_EN
    shown[15:12] = {2'b00, page_q};
`endif
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= BLANK;
      page_q    <= '0;
      blk_cnt_q <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      blk_cnt_q <= blk_cnt_d;
      disp_q    <= disp_d;
    end
  end

  // FSM next state; the blank count saturates so a stalled blank re-evaluates every cycle
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    blk_cnt_d = blk_cnt_q;
    case (state_q)
      SHOW: begin
        if (!bus.src_valid[page_q] || next_p || auto_adv) begin
          if (cand_found) begin
            page_d    = cand_page;
            state_d   = BLANK;
            blk_cnt_d = '0;
          end else if (!bus.src_valid[page_q]) begin
            state_d   = BLANK;
            blk_cnt_d = '0;
          end
        end
      end
      default: begin
        if (blk_cnt_q == BW'(BLANK_TICKS)) begin
          if (bus.src_valid[page_q]) begin
            state_d = SHOW;
          end else if (cand_found) begin
            page_d    = cand_page;
            blk_cnt_d = '0;
          end
        end else if (scan_tick) begin
          blk_cnt_d = blk_cnt_q + BW'(1);
        end
      end
    endcase
  end

  // FSM outputs; data loads on entry to SHOW so clr never uncovers a stale value
  always_comb begin
    clr_o  = (state_q == BLANK);
    disp_d = disp_q;
    if (state_d == SHOW) disp_d = shown;
  end

  assign bus.scan_tick = scan_tick;
  assign bus.disp_data = disp_q;
  assign bus.clr       = clr_o;
  assign bus.page      = page_q;
  assign bus.auto_mode = auto_mode_q;
endmodule
